// File: rtl/contador_mod.sv
// contador_mod: modulo-(LIM+1) counter with up/down/step-down modes, synchronous load and registered RCO.
// Latency: one cycle; ENB/MODO/D/LIM sampled at a rising edge are visible on Q/RCO right after that edge.
// Backpressure: none; ENB=0 holds Q and clears RCO. RCO may drive the ENB of a following stage (one-cycle skew).
//
// Ports:
//   CLK, RST_N  - clock and asynchronous active-low reset
//   ENB         - count/load enable
//   MODO        - 00 up by 1, 01 down by 1, 10 down by STEP, 11 load D
//   D, LIM      - load value and terminal value (count sequence is 0..LIM)
//   Q, RCO      - registered count and one-cycle wrap/borrow flag
// Parameters: WIDTH (>=2), STEP (1..2^WIDTH-1).
// Build option: define CONTADOR_MOD_SAT_EN to saturate at the ends instead of wrapping.
module contador_mod #(
    parameter int WIDTH = 16,
    parameter int STEP  = 3
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             ENB,
    input  logic [1:0]       MODO,
    input  logic [WIDTH-1:0] D,
    input  logic [WIDTH-1:0] LIM,
    output logic [WIDTH-1:0] Q,
    output logic             RCO
);

    localparam logic [1:0] MODO_UP   = 2'b00;
    localparam logic [1:0] MODO_DN   = 2'b01;
    localparam logic [1:0] MODO_DNS  = 2'b10;
    localparam logic [1:0] MODO_LOAD = 2'b11;

    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

    // Values taken at the three terminal events: up past LIM, down past 0,
    // and step-down with Q < STEP.
    logic [WIDTH-1:0] q_top;
    logic [WIDTH-1:0] q_bot;
    logic [WIDTH-1:0] q_stp;

`ifdef CONTADOR_MOD_SAT_EN
    assign q_top = LIM;
    assign q_bot = '0;
    assign q_stp = '0;
`else
    logic [WIDTH:0]   modulus;
    logic [WIDTH:0]   deficit;
    logic [WIDTH-1:0] wrap_val;

    assign modulus = {1'b0, LIM} + {{WIDTH{1'b0}}, 1'b1};

    // Step-down wrap result is (Q - STEP) mod (LIM+1). STEP can exceed the
    // modulus several times over, so the shortfall STEP-Q is reduced by
    // repeated subtraction; STEP iterations always suffice since the
    // modulus is at least 1. Only used when Q < STEP, so the shortfall is >= 1.
    always_comb begin
        deficit = {1'b0, STEP_W} - {1'b0, Q};
        for (int i = 0; i < STEP; i++) begin
            if (deficit >= modulus) begin
                deficit = deficit - modulus;
            end
        end
        if (deficit == '0) begin
            wrap_val = '0;
        end else begin
            wrap_val = WIDTH'(modulus - deficit);
        end
    end

    assign q_top = '0;
    assign q_bot = LIM;
    assign q_stp = wrap_val;
`endif

    logic [WIDTH-1:0] q_nxt;
    logic             rco_nxt;

    always_comb begin
        q_nxt   = Q;
        rco_nxt = 1'b0;
        if (ENB) begin
            case (MODO)
                MODO_UP: begin
                    // >= so a loaded value above LIM still terminates.
                    if (Q >= LIM) begin
                        q_nxt   = q_top;
                        rco_nxt = 1'b1;
                    end else begin
                        q_nxt = Q + WIDTH'(1);
                    end
                end
                MODO_DN: begin
                    if (Q == '0) begin
                        q_nxt   = q_bot;
                        rco_nxt = 1'b1;
                    end else begin
                        q_nxt = Q - WIDTH'(1);
                    end
                end
                MODO_DNS: begin
                    if (Q >= STEP_W) begin
                        q_nxt = Q - STEP_W;
                    end else begin
                        q_nxt   = q_stp;
                        rco_nxt = 1'b1;
                    end
                end
                MODO_LOAD: begin
                    q_nxt = D;
                end
                default: begin
                    q_nxt = Q;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            Q   <= '0;
            RCO <= 1'b0;
        end else begin
            Q   <= q_nxt;
            RCO <= rco_nxt;
        end
    end

endmodule

// File: tb/tb_contador_mod.sv
// Bench for contador_mod: directed vectors against a 4-bit and a 16-bit instance.
// Each vector drives inputs just after an edge, advances one edge, and compares Q/RCO.
// Expected values are hand-computed; both wrap and saturating builds are covered.
module tb_contador_mod;

`ifdef CONTADOR_MOD_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clk;
    logic        rst_n;

    logic        enb4;
    logic [1:0]  modo4;
    logic [3:0]  d4;
    logic [3:0]  lim4;
    logic [3:0]  q4;
    logic        rco4;

    logic        enb16;
    logic [1:0]  modo16;
    logic [15:0] d16;
    logic [15:0] lim16;
    logic [15:0] q16;
    logic        rco16;

    int checks   = 0;
    int failures = 0;

    contador_mod #(.WIDTH(4), .STEP(3)) u_cnt4 (
        .CLK   (clk),
        .RST_N (rst_n),
        .ENB   (enb4),
        .MODO  (modo4),
        .D     (d4),
        .LIM   (lim4),
        .Q     (q4),
        .RCO   (rco4)
    );

    contador_mod #(.WIDTH(16), .STEP(3)) u_cnt16 (
        .CLK   (clk),
        .RST_N (rst_n),
        .ENB   (enb16),
        .MODO  (modo16),
        .D     (d16),
        .LIM   (lim16),
        .Q     (q16),
        .RCO   (rco16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do4(input string tag, input logic e, input logic [1:0] m, input logic [3:0] d,
                       input logic [3:0] eq, input logic erco);
        enb4  = e;
        modo4 = m;
        d4    = d;
        tick();
        check({tag, ".q"}, 32'(q4), 32'(eq));
        check({tag, ".rco"}, 32'(rco4), 32'(erco));
    endtask

    task automatic do16(input string tag, input logic e, input logic [1:0] m, input logic [15:0] d,
                        input logic [15:0] eq, input logic erco);
        enb16  = e;
        modo16 = m;
        d16    = d;
        tick();
        check({tag, ".q"}, 32'(q16), 32'(eq));
        check({tag, ".rco"}, 32'(rco16), 32'(erco));
    endtask

    // Step-down sequence from 0 with LIM=15, STEP=3 (wrap build).
    logic [3:0] stp_q   [7] = '{4'd13, 4'd10, 4'd7, 4'd4, 4'd1, 4'd14, 4'd11};
    logic       stp_rco [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        rst_n = 1'b0;
        enb4 = 1'b0; modo4 = 2'b00; d4 = '0; lim4 = 4'd15;
        enb16 = 1'b0; modo16 = 2'b00; d16 = '0; lim16 = 16'd9;
        #12;
        check("rst.q4", 32'(q4), 32'd0);
        check("rst.rco4", 32'(rco4), 32'd0);
        check("rst.q16", 32'(q16), 32'd0);
        rst_n = 1'b1;
        tick();

        // Up count over the full 4-bit range.
        do4("up_load", 1'b1, 2'b11, 4'd0, 4'd0, 1'b0);
        for (int i = 1; i <= 16; i++) begin
            do4($sformatf("up%0d", i), 1'b1, 2'b00, 4'd0,
                (i == 16) ? (SAT ? 4'd15 : 4'd0) : 4'(i), (i == 16));
        end
        do4("up_after", 1'b1, 2'b00, 4'd0, SAT ? 4'd15 : 4'd1, SAT);

        // Step-down by 3 from 0.
        do4("stp_load", 1'b1, 2'b11, 4'd0, 4'd0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            do4($sformatf("stp%0d", i), 1'b1, 2'b10, 4'd0,
                SAT ? 4'd0 : stp_q[i], SAT ? 1'b1 : stp_rco[i]);
        end

        // Saturation-focused vectors (also meaningful in wrap build).
        do4("sat_load", 1'b1, 2'b11, 4'd14, 4'd14, 1'b0);
        do4("sat_up1", 1'b1, 2'b00, 4'd0, 4'd15, 1'b0);
        do4("sat_up2", 1'b1, 2'b00, 4'd0, SAT ? 4'd15 : 4'd0, 1'b1);
        do4("sat_up3", 1'b1, 2'b00, 4'd0, SAT ? 4'd15 : 4'd1, SAT);
        do4("sat_ld2", 1'b1, 2'b11, 4'd2, 4'd2, 1'b0);
        do4("sat_stp", 1'b1, 2'b10, 4'd0, SAT ? 4'd0 : 4'd15, 1'b1);
        enb4 = 1'b0;

        // BCD modulus on the 16-bit instance.
        do16("bcd_ld8", 1'b1, 2'b11, 16'd8, 16'd8, 1'b0);
        do16("bcd_up9", 1'b1, 2'b00, 16'd0, 16'd9, 1'b0);
        do16("bcd_upw", 1'b1, 2'b00, 16'd0, SAT ? 16'd9 : 16'd0, 1'b1);
        do16("bcd_ld0", 1'b1, 2'b11, 16'd0, 16'd0, 1'b0);
        do16("bcd_dn", 1'b1, 2'b01, 16'd0, SAT ? 16'd0 : 16'd9, 1'b1);
        do16("bcd_hold", 1'b0, 2'b01, 16'd0, SAT ? 16'd0 : 16'd9, 1'b0);
        do16("bcd_ld12", 1'b1, 2'b11, 16'd12, 16'd12, 1'b0);
        do16("bcd_up12", 1'b1, 2'b00, 16'd0, SAT ? 16'd9 : 16'd0, 1'b1);

        // Enable/hold.
        do16("hold_ld5", 1'b1, 2'b11, 16'd5, 16'd5, 1'b0);
        for (int i = 0; i < 4; i++) begin
            do16($sformatf("hold%0d", i), 1'b0, 2'b00, 16'd0, 16'd5, 1'b0);
        end
        do16("hold_up", 1'b1, 2'b00, 16'd0, 16'd6, 1'b0);

        // LIM=0 and STEP larger than the modulus.
        lim16 = 16'd0;
        do16("l0_up", 1'b1, 2'b00, 16'd0, 16'd0, 1'b1);
        do16("l0_dn", 1'b1, 2'b01, 16'd0, 16'd0, 1'b1);
        do16("l0_stp", 1'b1, 2'b10, 16'd0, 16'd0, 1'b1);
        lim16 = 16'd1;
        do16("l1_ld0", 1'b1, 2'b11, 16'd0, 16'd0, 1'b0);
        do16("l1_stp", 1'b1, 2'b10, 16'd0, SAT ? 16'd0 : 16'd1, 1'b1);

        // Asynchronous reset between edges.
        lim16 = 16'hFFFF;
        do16("ar_ld", 1'b1, 2'b11, 16'h1234, 16'h1234, 1'b0);
        enb16 = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("ar.q16", 32'(q16), 32'd0);
        check("ar.rco16", 32'(rco16), 32'd0);
        #1;
        rst_n = 1'b1;
        do16("ar_up", 1'b1, 2'b00, 16'd0, 16'd1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
